seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the CPU's combinational 8-bit ALU.
- Adds SUB, MUL, SLL and SRA, registered flags, and a START/BUSY/DONE handshake.
- Sits between the register-file read ports and the write-back mux. The control unit issues START and stalls the PC while BUSY=1.
- Single-cycle ops complete in 1 cycle. MUL and shifts iterate one step per clock.

Parameters:
- WIDTH, 8, operand/result width in bits (>=4).
- SHW, $clog2(WIDTH)+1, width of the internal shift/iteration counter.

Ports:
- CLK  input  1  clock, all state changes on rising edge.
- RESET  input  1  synchronous, active-high reset; clock CLK.
- START  input  1  request; accepted on an edge where BUSY=0.
- OP  input  3  000 FWD(DATA2), 001 ADD, 010 AND, 011 OR, 100 SUB(DATA1-DATA2), 101 MUL, 110 SLL(DATA1<<DATA2), 111 SRA(DATA1>>>DATA2).
- DATA1  input  WIDTH  operand A.
- DATA2  input  WIDTH  operand B / shift amount.
- READY  output  1  equals !BUSY.
- BUSY  output  1  an iteration is in progress.
- DONE  output  1  one-cycle pulse; RESULT and flags are valid and new.
- RESULT  output  WIDTH  registered result; holds until the next completion.
- ZERO  output  1  registered: RESULT==0.
- CARRY  output  1  registered, op-dependent (see below).

Behaviour:
- Reset (RESET=1 at an edge) clears state to IDLE and sets BUSY=0, DONE=0, RESULT=0, ZERO=0, CARRY=0.
  - RESET has priority over START.
  - RESET mid-operation aborts the operation; no DONE is produced.
- States:
  - IDLE: START accepted → if k>0 go to RUN, else go to IDLE with DONE=1.
  - RUN: counter decrements once per edge; the edge where the counter reaches 0 writes RESULT/flags, pulses DONE and returns to IDLE.
- Iteration count k:
  - FWD/ADD/AND/OR/SUB: k=0.
  - MUL: k=WIDTH.
  - SLL/SRA: k=min(DATA2 unsigned, WIDTH).
- Timing: START accepted at edge E → BUSY=1 for the k cycles after E. DONE=1 for exactly the one cycle after edge E+k.
- Operand capture:
  - DATA1, DATA2 and OP are latched at acceptance.
  - Input changes while BUSY=1 have no effect.
  - START while BUSY=1 is ignored (not queued).
- Back-to-back: START may be asserted in the DONE cycle and is accepted; DONE can therefore be high on consecutive cycles for k=0 ops.
- Arithmetic: all results are truncated to WIDTH, unsigned except SRA.
  - SUB = DATA1 + ~DATA2 + 1.
  - MUL is shift-add, one multiplier bit per cycle, LSB first, with a 2*WIDTH accumulator. RESULT is the low WIDTH bits.
  - SLL shifts in zeros. SRA shifts in copies of the MSB.
  - Shift amount >= WIDTH gives SLL result 0 and SRA result all-sign-bits.
- CARRY:
  - ADD: carry-out.
  - SUB: 1 when DATA1>=DATA2 unsigned (no borrow).
  - MUL: 1 when the upper WIDTH product bits are nonzero.
  - SLL/SRA: last bit shifted out, 0 if k=0.
  - FWD/AND/OR: 0.
- ZERO/CARRY are updated only on completion, together with RESULT.
- OP encodings are fully decoded; no X on any output after reset.

Test Plan:
1. WIDTH=8, ADD 200+100, then SUB 11-3, then SUB 3-11 back-to-back:
   - ADD → RESULT=44, CARRY=1, DONE one cycle after each START.
   - SUB 11-3 → 8, CARRY=1.
   - SUB 3-11 → 248, CARRY=0.
   - DONE high for 3 consecutive cycles.
2. MUL 13*11 → BUSY for 8 cycles, then DONE with RESULT=143, CARRY=0. MUL 20*20 → RESULT=144, CARRY=1. MUL 0*77 → ZERO=1.
3. SRA 0x90 by 3 → BUSY 3 cycles, RESULT=0xF2, CARRY=0. SLL 0x81 by 1 → RESULT=0x02, CARRY=1. SLL 0x81 by 9 → k=8, RESULT=0x00, ZERO=1. SRA by 0 → 1-cycle latency, RESULT=DATA1, CARRY=0.
4. Start MUL 13*11, then toggle DATA1/DATA2 and pulse START (ADD) at cycle 3 → the ADD is ignored; RESULT=143 after 8 busy cycles.
5. Assert RESET during cycle 4 of a MUL → next cycle BUSY=0, DONE=0, RESULT=0. No DONE pulse follows. A new FWD 0x5A completes normally with RESULT=0x5A.
6. WIDTH=16, MUL 300*300 → RESULT=90000 mod 65536 = 24464, CARRY=1, BUSY for 16 cycles.

Source files
------------

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic ops, iterative shift-add MUL and
// bit-serial shifts behind a START/BUSY/DONE handshake with registered flags.
module seq_alu #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic             READY,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             CARRY
);

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  localparam logic [SHW-1:0]   KMAX = SHW'(WIDTH);
  localparam logic [WIDTH-1:0] WLIM = WIDTH'(WIDTH);

  typedef enum logic {IDLE, RUN} state_e;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             carry;
  } rsp_t;

  state_e             state, state_n;
  logic [SHW-1:0]     cnt, cnt_n, k;
  logic [2:0]         op_q, op_n;
  logic [2*WIDTH-1:0] acc, acc_n, mcand, mcand_n;
  logic [WIDTH-1:0]   mplr, mplr_n;
  logic               shc, shc_n;
  logic               done_q, done_n;
  rsp_t               rsp, rsp_n, imm;
  logic [WIDTH:0]     sum, diff;

  // Result of the ops that finish in the acceptance cycle
  always_comb begin
    sum  = {1'b0, DATA1} + {1'b0, DATA2};
    diff = {1'b0, DATA1} + {1'b0, ~DATA2} + {{WIDTH{1'b0}}, 1'b1};
    imm  = '0;
    case (OP)
      OP_FWD:  imm.res = DATA2;
      OP_ADD:  {imm.carry, imm.res} = sum;
      OP_AND:  imm.res = DATA1 & DATA2;
      OP_OR:   imm.res = DATA1 | DATA2;
      OP_SUB:  {imm.carry, imm.res} = diff;
      default: imm.res = DATA1;  // zero-length shift
    endcase
    imm.zero = (imm.res == '0);
  end

  always_comb begin
    k = '0;
    if (OP == OP_MUL)
      k = KMAX;
    else if (OP == OP_SLL || OP == OP_SRA)
      k = (DATA2 >= WLIM) ? KMAX : DATA2[SHW-1:0];
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op_q;
    acc_n   = acc;
    mcand_n = mcand;
    mplr_n  = mplr;
    shc_n   = shc;
    rsp_n   = rsp;
    done_n  = 1'b0;
    if (state == IDLE) begin
      if (START) begin
        op_n    = OP;
        cnt_n   = k;
        acc_n   = (OP == OP_MUL) ? '0 : {{WIDTH{1'b0}}, DATA1};
        mcand_n = {{WIDTH{1'b0}}, DATA1};
        mplr_n  = DATA2;
        shc_n   = 1'b0;
        if (k == '0) begin
          rsp_n  = imm;
          done_n = 1'b1;
        end else begin
          state_n = RUN;
        end
      end
    end else begin
      cnt_n = cnt - SHW'(1);
      case (op_q)
        OP_MUL: begin
          if (mplr[0]) acc_n = acc + mcand;
          mcand_n = mcand << 1;
          mplr_n  = mplr >> 1;
        end
        OP_SLL: begin
          shc_n = acc[WIDTH-1];
          acc_n = {{WIDTH{1'b0}}, acc[WIDTH-2:0], 1'b0};
        end
        OP_SRA: begin
          shc_n = acc[0];
          acc_n = {{WIDTH{1'b0}}, acc[WIDTH-1], acc[WIDTH-1:1]};
        end
        default: ;
      endcase
      // Counter hits zero on this edge: publish result and flags
      if (cnt == SHW'(1)) begin
        rsp_n.res   = acc_n[WIDTH-1:0];
        rsp_n.carry = (op_q == OP_MUL) ? |acc_n[2*WIDTH-1:WIDTH] : shc_n;
        rsp_n.zero  = (acc_n[WIDTH-1:0] == '0);
        done_n      = 1'b1;
        state_n     = IDLE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= OP_FWD;
      acc    <= '0;
      mcand  <= '0;
      mplr   <= '0;
      shc    <= 1'b0;
      rsp    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      op_q   <= op_n;
      acc    <= acc_n;
      mcand  <= mcand_n;
      mplr   <= mplr_n;
      shc    <= shc_n;
      rsp    <= rsp_n;
      done_q <= done_n;
    end
  end

  assign BUSY   = (state == RUN);
  assign READY  = ~BUSY;
  assign DONE   = done_q;
  assign RESULT = rsp.res;
  assign ZERO   = rsp.zero;
  assign CARRY  = rsp.carry;

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu: WIDTH=8 instance for the bulk of the
// vectors, WIDTH=16 instance for the wide multiply.
module tb_seq_alu;

  localparam logic [2:0] FWD = 3'b000, ADD = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                         SUB = 3'b100, MUL = 3'b101, SLL = 3'b110, SRA = 3'b111;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        start;
  logic [2:0]  op;
  logic [7:0]  d1, d2;
  logic        ready, busy, done, zero, carry;
  logic [7:0]  result;

  logic        start16;
  logic [2:0]  op16;
  logic [15:0] a16, b16;
  logic        ready16, busy16, done16, zero16, carry16;
  logic [15:0] result16;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  seq_alu #(.WIDTH(8)) u_dut8 (
    .CLK(CLK), .RESET(RESET), .START(start), .OP(op), .DATA1(d1), .DATA2(d2),
    .READY(ready), .BUSY(busy), .DONE(done), .RESULT(result), .ZERO(zero), .CARRY(carry)
  );

  seq_alu #(.WIDTH(16)) u_dut16 (
    .CLK(CLK), .RESET(RESET), .START(start16), .OP(op16), .DATA1(a16), .DATA2(b16),
    .READY(ready16), .BUSY(busy16), .DONE(done16), .RESULT(result16), .ZERO(zero16),
    .CARRY(carry16)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Issue one op on the 8-bit DUT and check latency, result, flags and pulse width
  task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] a,
                        input logic [7:0] b, input int k, input logic [7:0] er,
                        input logic ec, input logic ez);
    int nb, cyc;
    start = 1'b1; op = o; d1 = a; d2 = b;
    step();
    start = 1'b0;
    nb = 0; cyc = 0;
    while (!done && cyc < 40) begin
      if (busy) nb++;
      cyc++;
      step();
    end
    chk({tag, ".done"},   done,   1);
    chk({tag, ".busy"},   nb,     k);
    chk({tag, ".lat"},    cyc,    k);
    chk({tag, ".result"}, result, er);
    chk({tag, ".carry"},  carry,  ec);
    chk({tag, ".zero"},   zero,   ez);
    chk({tag, ".ready"},  ready,  1);
    step();
    chk({tag, ".pulse"},  done,   0);
  endtask

  initial begin
    int nb, cyc, ndone;
    RESET = 1'b1; start = 1'b1; op = FWD; d1 = 8'h00; d2 = 8'h77;
    start16 = 1'b0; op16 = FWD; a16 = '0; b16 = '0;
    step(); step();
    chk("rst.busy", busy, 0);
    chk("rst.ready", ready, 1);
    chk("rst.done", done, 0);
    chk("rst.result", result, 0);
    chk("rst.zero", zero, 0);
    chk("rst.carry", carry, 0);
    chk("rst.busy16", busy16, 0);
    RESET = 1'b0; start = 1'b0;
    step();
    chk("rst.prio", done, 0);

    // 1: back-to-back single-cycle ops, DONE high three cycles in a row
    start = 1'b1; op = ADD; d1 = 8'd200; d2 = 8'd100;
    step();
    chk("b2b.add.done", done, 1);
    chk("b2b.add.res", result, 44);
    chk("b2b.add.c", carry, 1);
    op = SUB; d1 = 8'd11; d2 = 8'd3;
    step();
    chk("b2b.sub1.done", done, 1);
    chk("b2b.sub1.res", result, 8);
    chk("b2b.sub1.c", carry, 1);
    d1 = 8'd3; d2 = 8'd11;
    step();
    chk("b2b.sub2.done", done, 1);
    chk("b2b.sub2.res", result, 248);
    chk("b2b.sub2.c", carry, 0);
    chk("b2b.sub2.z", zero, 0);
    start = 1'b0;
    step();
    chk("b2b.end", done, 0);

    run_op("fwd",  FWD,  8'h11, 8'hA5, 0, 8'hA5, 0, 0);
    run_op("and",  AND_, 8'hF0, 8'h3C, 0, 8'h30, 0, 0);
    run_op("or",   OR_,  8'hF0, 8'h3C, 0, 8'hFC, 0, 0);
    run_op("addz", ADD,  8'h80, 8'h80, 0, 8'h00, 1, 1);
    run_op("subeq", SUB, 8'd7,  8'd7,  0, 8'h00, 1, 1);

    // 2: multiply
    run_op("mul13x11", MUL, 8'd13, 8'd11, 8, 8'd143, 0, 0);
    run_op("mul20x20", MUL, 8'd20, 8'd20, 8, 8'd144, 1, 0);
    run_op("mul0x77",  MUL, 8'd0,  8'd77, 8, 8'd0,   0, 1);

    // 3: shifts
    run_op("sra3",   SRA, 8'h90, 8'd3,   3, 8'hF2, 0, 0);
    run_op("sll1",   SLL, 8'h81, 8'd1,   1, 8'h02, 1, 0);
    run_op("sll9",   SLL, 8'h81, 8'd9,   8, 8'h00, 1, 1);
    run_op("sra0",   SRA, 8'h90, 8'd0,   0, 8'h90, 0, 0);
    run_op("sra200", SRA, 8'h90, 8'd200, 8, 8'hFF, 1, 0);

    // 4: inputs and START while busy are ignored
    start = 1'b1; op = MUL; d1 = 8'd13; d2 = 8'd11;
    step();
    start = 1'b0;
    nb = 0; cyc = 0;
    while (!done && cyc < 40) begin
      if (busy) nb++;
      if (cyc == 2) begin start = 1'b1; op = ADD; d1 = 8'd1; d2 = 8'd2; end
      if (cyc == 3) start = 1'b0;
      cyc++;
      step();
    end
    chk("ign.done", done, 1);
    chk("ign.busy", nb, 8);
    chk("ign.res", result, 143);
    step();
    chk("ign.noq.done", done, 0);
    chk("ign.noq.busy", busy, 0);

    // 5: reset mid-MUL aborts without a DONE
    start = 1'b1; op = MUL; d1 = 8'd13; d2 = 8'd11;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("abort.busy.pre", busy, 1);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    chk("abort.res", result, 0);
    chk("abort.carry", carry, 0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) ndone++;
      step();
    end
    chk("abort.quiet", ndone, 0);
    run_op("fwd5a", FWD, 8'h00, 8'h5A, 0, 8'h5A, 0, 0);

    // 6: WIDTH=16 multiply
    start16 = 1'b1; op16 = MUL; a16 = 16'd300; b16 = 16'd300;
    step();
    start16 = 1'b0;
    nb = 0; cyc = 0;
    while (!done16 && cyc < 60) begin
      if (busy16) nb++;
      cyc++;
      step();
    end
    chk("w16.done", done16, 1);
    chk("w16.busy", nb, 16);
    chk("w16.res", result16, 24464);
    chk("w16.carry", carry16, 1);
    chk("w16.zero", zero16, 0);
    step();
    chk("w16.pulse", done16, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
